core_dispatch_arbiter: RTL and testbench
========================================

# core_dispatch_arbiter

Sample dispatcher and result collector for the multicore array. It sits between the single signed-sample source and the NCORES processing cores. It hands each incoming sample to one requesting core, chosen round-robin. It also captures each core's one-cycle result pulse and serializes all results onto one valid/ready output stream tagged with the core index.

## Interface
- NCORES, 51, number of cores
- IN_W, 19, signed input sample width
- OUT_W, 28, signed core result width
- CIDX_W, $clog2(NCORES), core index width

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  IN_W  signed sample from source
- s_valid  in  1  sample available
- s_ready  out  1  sample accepted this cycle (s_valid & s_ready)
- req_in  in  4*NCORES  per-core request code; request asserted when the core's nibble == 4'd1
- in_data  out  IN_W  dispatched sample, shared by all cores
- in_grant  out  NCORES  one-hot, one-cycle pulse marking the target core
- out_en  in  4*NCORES  per-core result strobe; valid when the nibble == 4'd1
- io_out  in  OUT_W*NCORES  per-core signed results
- m_data  out  OUT_W  serialized result
- m_core  out  CIDX_W  source core of m_data
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts
- ovf  out  NCORES  sticky per-core result-overflow flag
- stat_disp, stat_coll  out  32 each  dispatch and collect counters (see Configuration)

## Operation
- Reset values: s_ready 0, in_data 0, in_grant 0, m_data 0, m_core 0, m_valid 0, ovf 0, pending 0, holding-full 0, both round-robin pointers 0, counters 0. Reset is asynchronous and may occur at any time. It discards all pending requests and held results.
- Request capture: req_in nibble == 1 sets pending[i]. The grant clears pending[i]. A re-request while still pending is absorbed.
- Dispatch FSM:
  - IDLE: s_ready = |pending.
  - On s_valid & s_ready: pick the first pending core at or after ptr_in, wrapping. Register in_data = s_data, in_grant = onehot(k), clear pending[k], set ptr_in = (k+1) mod NCORES. Go to ISSUE.
  - ISSUE: in_grant high for exactly this cycle, s_ready 0. Go to IDLE.
  - in_data holds its value until the next grant.
- Result capture:
  - out_en nibble == 1 loads hold[i] = io_out[i] and sets full[i].
  - If full[i] is already set and not draining this cycle: the new value is dropped, the old one is kept, and ovf[i] sets. ovf clears only on reset.
  - If capture and drain of the same core coincide: the capture wins, full[i] stays 1, and ovf is not set.
- Collection:
  - When m_valid is 0 or m_valid & m_ready: pick the first full core at or after ptr_out, wrapping. Load m_data and m_core, clear full[k], set ptr_out = (k+1) mod NCORES.
  - If no core is full, m_valid drops.
  - m_data and m_core stay stable while m_valid & !m_ready.
- Arithmetic: data is passed through unchanged, with no extension or truncation. Wrap of both pointers is NCORES-1 -> 0.

## Timing
- req_in seen at edge N -> s_ready high in cycle N+1. If s_valid, in_grant pulses after edge N+1. Next s_ready is no earlier than after edge N+2.
- Peak dispatch rate: 1 sample per 2 cycles.
- out_en seen at edge N -> m_valid high after edge N+1 when the output is idle and no other core is full.
- Sustained collection rate: 1 result per cycle with m_ready = 1.
- Worst-case service delay: NCORES-1 grants on each side.

## Configuration
- DISPATCH_STATS_EN defined:
  - stat_disp increments per grant, stat_coll per m_valid & m_ready handshake.
  - Both are 32-bit, wrap at 2^32, reset to 0.
- Not defined: both ports are tied to 0 and no counter logic is built.

## Structure
- Package multicore_pkg: NCORES, IN_W, OUT_W, CIDX_W, REQ_CODE = 4'd1, dispatch state enum {IDLE, ISSUE}.
- Sub-module rr_pick (request vector, pointer -> one-hot grant, index, any), instantiated twice: once for dispatch, once for collection.

## Test plan
- Core 3 requests, s_data = -1234, s_valid = 1 -> s_ready 1 cycle, in_grant = bit 3 one cycle, in_data = -1234, pending clear.
- Cores 0, 5, 50 request together, ptr 0, s_valid held -> grants in order 0, 5, 50, two cycles apart. ptr_in ends at 0 (wrap).
- All 51 out_en together, io_out[i] = i*1000 - 25000, m_ready = 1 -> 51 consecutive beats, m_core 0..50, exact values, then m_valid 0.
- m_ready = 0, core 7 out_en with 111 then 222 -> ovf[7] = 1, m_data = 111 when released, 222 never appears.
- rst_n dropped mid-collection with 10 results held -> m_valid, in_grant, s_ready 0 immediately. After release, no stale beat and pointers at 0.
- With DISPATCH_STATS_EN, after scenarios 2 and 3 -> stat_disp = 3, stat_coll = 51. Without the macro -> both 0.

Source files
------------

// File: rtl/multicore_pkg.sv
// Shared sizes, request code and dispatch state encoding for the multicore
// sample dispatcher / result collector.
package multicore_pkg;

    localparam int NCORES = 51;
    localparam int IN_W   = 19;
    localparam int OUT_W  = 28;
    localparam int CIDX_W = $clog2(NCORES);

    // Nibble value a core drives to request a sample or flag a result.
    localparam logic [3:0] REQ_CODE = 4'd1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } disp_state_t;

    // Round-robin successor of a core index, wrapping NCORES-1 -> 0.
    function automatic logic [CIDX_W-1:0] next_idx(input logic [CIDX_W-1:0] idx);
        return (idx == CIDX_W'(NCORES - 1)) ? '0 : idx + CIDX_W'(1);
    endfunction

endpackage

// File: rtl/core_dispatch_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first asserted
// request at or after ptr, wrapping to the lowest asserted request below ptr.
module rr_pick
    import multicore_pkg::*;
#(
    parameter int N  = NCORES,
    parameter int IW = CIDX_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_lo;
    logic          found_hi;
    logic          found_lo;

    // Scan downward so the lowest matching index wins in each half of the ring.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_lo   = IW'(i);
                found_lo = 1'b1;
                if (IW'(i) >= ptr) begin
                    idx_hi   = IW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        any   = found_lo;
        idx   = found_hi ? idx_hi : idx_lo;
        grant = found_lo ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/core_dispatch_arbiter.sv
// core_dispatch_arbiter: hands source samples to requesting cores round-robin
// and serializes per-core result pulses onto one valid/ready stream.
// Optional feature macro DISPATCH_STATS_EN builds the grant/handshake counters;
// without it stat_disp and stat_coll are constant zero.
module core_dispatch_arbiter
    import multicore_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [IN_W-1:0]      s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [4*NCORES-1:0]         req_in,
    output logic signed [IN_W-1:0]      in_data,
    output logic [NCORES-1:0]           in_grant,
    input  logic [4*NCORES-1:0]         out_en,
    input  logic [OUT_W*NCORES-1:0]     io_out,
    output logic signed [OUT_W-1:0]     m_data,
    output logic [CIDX_W-1:0]           m_core,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [NCORES-1:0]           ovf,
    output logic [31:0]                 stat_disp,
    output logic [31:0]                 stat_coll
);

    disp_state_t              state;
    logic [NCORES-1:0]        pending;
    logic [NCORES-1:0]        pending_next;
    logic [NCORES-1:0]        req_set;
    logic [NCORES-1:0]        cap_set;
    logic [NCORES-1:0]        full;
    logic [NCORES-1:0]        drain;
    logic [CIDX_W-1:0]        ptr_in;
    logic [CIDX_W-1:0]        ptr_out;
    logic [NCORES-1:0]        disp_grant;
    logic [NCORES-1:0]        coll_grant;
    logic [CIDX_W-1:0]        disp_idx;
    logic [CIDX_W-1:0]        coll_idx;
    logic                     disp_any;
    logic                     coll_any;
    logic                     fire;
    logic                     load;
    logic signed [OUT_W-1:0]  hold [NCORES];

    rr_pick u_pick_disp (
        .req   (pending),
        .ptr   (ptr_in),
        .grant (disp_grant),
        .idx   (disp_idx),
        .any   (disp_any)
    );

    rr_pick u_pick_coll (
        .req   (full),
        .ptr   (ptr_out),
        .grant (coll_grant),
        .idx   (coll_idx),
        .any   (coll_any)
    );

    // s_ready is only ever high in IDLE with something pending.
    assign fire  = (state == IDLE) && s_valid && s_ready && disp_any;
    assign load  = !m_valid || m_ready;
    assign drain = (load && coll_any) ? coll_grant : '0;

    // A grant retires the request it serves; a repeat request is absorbed.
    assign pending_next = (pending | req_set) & ~(fire ? disp_grant : '0);

    // Per-core request decode, result capture and overflow tracking.
    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
            logic                    full_bit;
            logic                    ovf_bit;
            logic signed [OUT_W-1:0] hold_val;
            logic                    accept;

            assign req_set[gi] = (req_in[4*gi +: 4] == REQ_CODE);
            assign cap_set[gi] = (out_en[4*gi +: 4] == REQ_CODE);
            // A slot still occupied and not leaving this cycle refuses new data.
            assign accept      = cap_set[gi] && !(full_bit && !drain[gi]);

            // Occupancy and sticky overflow for this core's result slot.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    full_bit <= 1'b0;
                    ovf_bit  <= 1'b0;
                end else if (cap_set[gi]) begin
                    if (accept) full_bit <= 1'b1;
                    else        ovf_bit  <= 1'b1;
                end else if (drain[gi]) begin
                    full_bit <= 1'b0;
                end
            end

            // Result payload; only meaningful while full_bit is set.
            always_ff @(posedge clk) begin
                if (accept) hold_val <= io_out[OUT_W*gi +: OUT_W];
            end

            assign full[gi] = full_bit;
            assign ovf[gi]  = ovf_bit;
            assign hold[gi] = hold_val;
        end
    endgenerate

    // Dispatch FSM: one grant pulse per accepted sample, then one idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_ready  <= 1'b0;
            in_data  <= '0;
            in_grant <= '0;
            ptr_in   <= '0;
            pending  <= '0;
        end else begin
            pending <= pending_next;
            case (state)
                IDLE: begin
                    if (fire) begin
                        in_data  <= s_data;
                        in_grant <= disp_grant;
                        ptr_in   <= next_idx(disp_idx);
                        s_ready  <= 1'b0;
                        state    <= ISSUE;
                    end else begin
                        s_ready  <= |pending_next;
                    end
                end
                ISSUE: begin
                    in_grant <= '0;
                    s_ready  <= |pending_next;
                    state    <= IDLE;
                end
                default: begin
                    in_grant <= '0;
                    s_ready  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Output stage: refill whenever empty or the current beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_core  <= '0;
            ptr_out <= '0;
        end else if (load) begin
            if (coll_any) begin
                m_valid <= 1'b1;
                m_data  <= hold[coll_idx];
                m_core  <= coll_idx;
                ptr_out <= next_idx(coll_idx);
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    // Free-running wrap-around counts of grants and output handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_disp <= '0;
            stat_coll <= '0;
        end else begin
            if (fire)              stat_disp <= stat_disp + 32'd1;
            if (m_valid && m_ready) stat_coll <= stat_coll + 32'd1;
        end
    end
`else
    assign stat_disp = '0;
    assign stat_coll = '0;
`endif

endmodule

// File: tb/tb_core_dispatch_arbiter.sv
// Directed testbench for core_dispatch_arbiter; honours DISPATCH_STATS_EN.
module tb_core_dispatch_arbiter;
    import multicore_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic signed [IN_W-1:0]   s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic [4*NCORES-1:0]      req_in;
    logic signed [IN_W-1:0]   in_data;
    logic [NCORES-1:0]        in_grant;
    logic [4*NCORES-1:0]      out_en;
    logic [OUT_W*NCORES-1:0]  io_out;
    logic signed [OUT_W-1:0]  m_data;
    logic [CIDX_W-1:0]        m_core;
    logic                     m_valid;
    logic                     m_ready;
    logic [NCORES-1:0]        ovf;
    logic [31:0]              stat_disp;
    logic [31:0]              stat_coll;

    int checks   = 0;
    int failures = 0;

    core_dispatch_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .req_in    (req_in),
        .in_data   (in_data),
        .in_grant  (in_grant),
        .out_en    (out_en),
        .io_out    (io_out),
        .m_data    (m_data),
        .m_core    (m_core),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .ovf       (ovf),
        .stat_disp (stat_disp),
        .stat_coll (stat_coll)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Advance one clock and land on the following falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int idx);
        req_in[4*idx +: 4] = 4'd1;
    endtask

    task automatic set_res(input int idx, input int val);
        out_en[4*idx +: 4]         = 4'd1;
        io_out[OUT_W*idx +: OUT_W] = OUT_W'(val);
    endtask

    function automatic logic [NCORES-1:0] bit_of(input int idx);
        logic [NCORES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic int onehot_idx(input logic [NCORES-1:0] v);
        int n = 0;
        int k = -1;
        for (int i = 0; i < NCORES; i++) if (v[i]) begin n++; k = i; end
        return (n == 1) ? k : -1;
    endfunction

    task automatic clear_inputs();
        s_data  = '0;
        s_valid = 1'b0;
        req_in  = '0;
        out_en  = '0;
        io_out  = '0;
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %0b expected 0", s_ready); end
        checks++; if (in_data !== '0) begin failures++; $display("FAIL reset_in_data: got %0d expected 0", in_data); end
        checks++; if (in_grant !== '0) begin failures++; $display("FAIL reset_in_grant: got %h expected 0", in_grant); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
        checks++; if (m_data !== '0 || m_core !== '0) begin failures++; $display("FAIL reset_m_data: got %0d/%0d expected 0/0", m_data, m_core); end
        checks++; if (ovf !== '0) begin failures++; $display("FAIL reset_ovf: got %h expected 0", ovf); end
        checks++; if (stat_disp !== 32'd0 || stat_coll !== 32'd0) begin failures++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_disp, stat_coll); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_dispatch();
        logic signed [IN_W-1:0] exp_d;
        exp_d   = -1234;
        set_req(3);
        s_data  = exp_d;
        s_valid = 1'b1;
        tick();
        req_in = '0;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %0b expected 1", s_ready); end
        checks++; if (in_grant !== '0) begin failures++; $display("FAIL single_early_grant: got %h expected 0", in_grant); end
        tick();
        checks++; if (in_grant !== bit_of(3)) begin failures++; $display("FAIL single_grant: got %h expected %h", in_grant, bit_of(3)); end
        checks++; if (in_data !== exp_d) begin failures++; $display("FAIL single_in_data: got %0d expected %0d", in_data, exp_d); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL single_ready_issue: got %0b expected 0", s_ready); end
        s_valid = 1'b0;
        tick();
        checks++; if (in_grant !== '0) begin failures++; $display("FAIL single_grant_pulse: got %h expected 0", in_grant); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL single_pending_clear: got %0b expected 0", s_ready); end
        checks++; if (in_data !== exp_d) begin failures++; $display("FAIL single_in_data_hold: got %0d expected %0d", in_data, exp_d); end
    endtask

    task automatic test_rr_dispatch();
        int gidx[$];
        int gcyc[$];
        int exp_i[3] = '{0, 5, 50};
        int exp_c[3] = '{1, 3, 5};
        int got;
        set_req(0); set_req(5); set_req(50);
        s_data  = -5;
        s_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) req_in = '0;
            if (in_grant !== '0) begin
                gidx.push_back(onehot_idx(in_grant));
                gcyc.push_back(c);
            end
        end
        s_valid = 1'b0;
        checks++; if (gidx.size() != 3) begin failures++; $display("FAIL rr_grant_count: got %0d expected 3", gidx.size()); end
        for (int j = 0; j < 3; j++) begin
            got = (j < gidx.size()) ? gidx[j] : -1;
            checks++; if (got != exp_i[j]) begin failures++; $display("FAIL rr_grant_order[%0d]: got core %0d expected %0d", j, got, exp_i[j]); end
            got = (j < gcyc.size()) ? gcyc[j] : -1;
            checks++; if (got != exp_c[j]) begin failures++; $display("FAIL rr_grant_cycle[%0d]: got %0d expected %0d", j, got, exp_c[j]); end
        end
        checks++; if (in_data !== IN_W'(-5)) begin failures++; $display("FAIL rr_in_data: got %0d expected -5", in_data); end
    endtask

    task automatic test_collect_all();
        logic signed [OUT_W-1:0] exp_m;
        m_ready = 1'b1;
        for (int i = 0; i < NCORES; i++) set_res(i, i * 1000 - 25000);
        tick();
        out_en = '0;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL coll_latency: got m_valid %0b expected 0", m_valid); end
        for (int b = 0; b < NCORES; b++) begin
            tick();
            exp_m = OUT_W'(b * 1000 - 25000);
            checks++;
            if (m_valid !== 1'b1 || m_core !== CIDX_W'(b) || m_data !== exp_m) begin
                failures++;
                $display("FAIL coll_beat[%0d]: got v=%0b core=%0d data=%0d expected v=1 core=%0d data=%0d",
                         b, m_valid, m_core, m_data, b, exp_m);
            end
        end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL coll_drain_end: got m_valid %0b expected 0", m_valid); end
    endtask

    task automatic test_stats();
`ifdef DISPATCH_STATS_EN
        checks++; if (stat_disp !== 32'd3) begin failures++; $display("FAIL stat_disp: got %0d expected 3", stat_disp); end
        checks++; if (stat_coll !== 32'd51) begin failures++; $display("FAIL stat_coll: got %0d expected 51", stat_coll); end
`else
        checks++; if (stat_disp !== 32'd0) begin failures++; $display("FAIL stat_disp: got %0d expected 0", stat_disp); end
        checks++; if (stat_coll !== 32'd0) begin failures++; $display("FAIL stat_coll: got %0d expected 0", stat_coll); end
`endif
    endtask

    // Both pointers wrapped to 0 in the previous scenarios; 0 must beat 50.
    task automatic test_ptr_wrap();
        set_req(0); set_req(50);
        s_data  = 77;
        s_valid = 1'b1;
        tick();
        req_in = '0;
        tick();
        checks++; if (in_grant !== bit_of(0)) begin failures++; $display("FAIL wrap_disp_first: got %h expected %h", in_grant, bit_of(0)); end
        tick();
        tick();
        checks++; if (in_grant !== bit_of(50)) begin failures++; $display("FAIL wrap_disp_second: got %h expected %h", in_grant, bit_of(50)); end
        s_valid = 1'b0;
        tick();
        m_ready = 1'b1;
        set_res(0, 7); set_res(50, 9);
        tick();
        out_en = '0;
        tick();
        checks++; if (m_valid !== 1'b1 || m_core !== CIDX_W'(0) || m_data !== OUT_W'(7)) begin failures++; $display("FAIL wrap_coll_first: got core=%0d data=%0d expected core=0 data=7", m_core, m_data); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_core !== CIDX_W'(50) || m_data !== OUT_W'(9)) begin failures++; $display("FAIL wrap_coll_second: got core=%0d data=%0d expected core=50 data=9", m_core, m_data); end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL wrap_coll_end: got m_valid %0b expected 0", m_valid); end
    endtask

    // Capture and drain of the same core in one cycle keep both values.
    task automatic test_capture_drain();
        m_ready = 1'b1;
        set_res(2, 10);
        tick();
        set_res(2, 20);
        tick();
        out_en = '0;
        checks++; if (m_valid !== 1'b1 || m_core !== CIDX_W'(2) || m_data !== OUT_W'(10)) begin failures++; $display("FAIL cd_first: got v=%0b core=%0d data=%0d expected v=1 core=2 data=10", m_valid, m_core, m_data); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_core !== CIDX_W'(2) || m_data !== OUT_W'(20)) begin failures++; $display("FAIL cd_second: got v=%0b core=%0d data=%0d expected v=1 core=2 data=20", m_valid, m_core, m_data); end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL cd_end: got m_valid %0b expected 0", m_valid); end
        checks++; if (ovf !== '0) begin failures++; $display("FAIL cd_no_ovf: got %h expected 0", ovf); end
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        set_res(1, 555);
        tick();
        out_en = '0;
        set_res(7, 111);
        tick();
        set_res(7, 222);
        tick();
        out_en = '0;
        checks++; if (ovf !== bit_of(7)) begin failures++; $display("FAIL ovf_flag: got %h expected %h", ovf, bit_of(7)); end
        checks++; if (m_valid !== 1'b1 || m_core !== CIDX_W'(1) || m_data !== OUT_W'(555)) begin failures++; $display("FAIL ovf_head: got core=%0d data=%0d expected core=1 data=555", m_core, m_data); end
        tick();
        tick();
        checks++; if (m_valid !== 1'b1 || m_core !== CIDX_W'(1) || m_data !== OUT_W'(555)) begin failures++; $display("FAIL ovf_stall_stable: got core=%0d data=%0d expected core=1 data=555", m_core, m_data); end
        m_ready = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b1 || m_core !== CIDX_W'(7) || m_data !== OUT_W'(111)) begin failures++; $display("FAIL ovf_kept_old: got core=%0d data=%0d expected core=7 data=111", m_core, m_data); end
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL ovf_dropped_new: got v=%0b data=%0d expected v=0", m_valid, m_data); end
        checks++; if (ovf !== bit_of(7)) begin failures++; $display("FAIL ovf_sticky: got %h expected %h", ovf, bit_of(7)); end
    endtask

    task automatic test_reset_mid();
        bit stale = 1'b0;
        // Move ptr_in off zero with one dispatch to core 4.
        set_req(4);
        s_valid = 1'b1;
        tick();
        req_in = '0;
        tick();
        s_valid = 1'b0;
        tick();
        // Hold 10 results behind a stalled output and leave core 20 pending.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) set_res(i, 100 + i);
        set_req(20);
        tick();
        out_en = '0;
        req_in = '0;
        tick();
        checks++; if (m_valid !== 1'b1 || s_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_pre: got v=%0b s_ready=%0b expected 1/1", m_valid, s_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || in_grant !== '0 || s_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_async: got v=%0b grant=%h s_ready=%0b expected all 0", m_valid, in_grant, s_ready); end
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (m_valid !== 1'b0 || s_ready !== 1'b0) stale = 1'b1;
        end
        checks++; if (stale) begin failures++; $display("FAIL rst_mid_stale: got stale beat or request, expected none"); end
        set_res(0, 3); set_res(40, 4);
        set_req(0); set_req(10);
        s_valid = 1'b1;
        tick();
        out_en = '0;
        req_in = '0;
        tick();
        checks++; if (m_valid !== 1'b1 || m_core !== CIDX_W'(0)) begin failures++; $display("FAIL rst_mid_ptr_out: got v=%0b core=%0d expected v=1 core=0", m_valid, m_core); end
        checks++; if (in_grant !== bit_of(0)) begin failures++; $display("FAIL rst_mid_ptr_in: got %h expected %h", in_grant, bit_of(0)); end
        s_valid = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_dispatch();
        do_reset();
        test_rr_dispatch();
        test_collect_all();
        test_stats();
        test_ptr_wrap();
        test_capture_drain();
        test_overflow();
        do_reset();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
